sm4_masked_ltrans: RTL and testbench
====================================

Name: sm4_masked_ltrans

Overview:
Downstream neighbour of the masked SubNibble (τ) stage in the SM4 datapath.
- Consumes the masked S-box output share pair (x, m) and applies the SM4 linear transform to each share independently. L is linear, so the Boolean masking is preserved without remasking.
- XORs in the masked round word X0 (shares x0, m0) to produce the new masked state word.
- Term accumulation is serialised, one rotation per cycle, to save area; the start/finish handshake matches the τ stage.

Parameters:
- KEY_MODE, default 0: selects the transform.
  - 0 = round transform L(B) = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24.
  - 1 = key-schedule transform L'(B) = B ^ B<<<13 ^ B<<<23.
- NTERMS, derived (not overridable): 4 when KEY_MODE=0, 2 when KEY_MODE=1. Equals the number of rotation terms.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level request; sampled only in IDLE.
- x  in  32  masked share of τ output (x_out of SubNibble).
- m  in  32  mask share of τ output (m_out of SubNibble).
- x0  in  32  masked share of round word X0.
- m0  in  32  mask share of round word X0.
- finish  out  1  one-cycle completion pulse.
- x_out  out  32  L(x) ^ x0.
- m_out  out  32  L(m) ^ m0.
- busy  out  1  high in ACC and DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cnt=0, all internal accumulators and rotation registers = 0, finish=0, busy=0, x_out=0, m_out=0. Reset asserted mid-operation aborts immediately. No finish pulse is produced for the aborted operation.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - Edge with start=1 latches x, m, x0, m0.
  - Both accumulators are loaded with the identity term (acc_x=x, acc_m=m).
  - cnt=0; go to ACC.
  - start=0: hold; outputs keep their last values.
- ACC (NTERMS cycles, cnt 0..NTERMS-1):
  - Each edge XORs rotl(latched share, R[cnt]) into the accumulator, for both shares in the same cycle.
  - Rotation table: KEY_MODE=0 uses R = {2, 10, 18, 24}; KEY_MODE=1 uses R = {13, 23}.
  - The edge with cnt==NTERMS-1 does the following:
    - registers x_out = acc_x ^ rotl(x, R[last]) ^ x0_latched, and m_out likewise using the m shares.
    - sets finish=1.
    - goes to DONE.
- DONE: one cycle. Next edge clears finish and goes to IDLE.
- Latency: start sampled at edge E0 → finish high after edge E(NTERMS), i.e. 4 cycles (KEY_MODE=0) or 2 cycles (KEY_MODE=1). finish is high for exactly one cycle.
- Throughput: one word per NTERMS+2 cycles.
- Handshake:
  - start is ignored while busy=1. Inputs may change freely after E0 because they are latched.
  - If start is still high on the first IDLE edge after DONE, a new operation begins with the current inputs. A held-high start therefore re-issues continuously, matching the τ stage bench style.
- Output hold: x_out and m_out change only on the finishing edge (or reset) and are valid when finish=1.
- Masking rule: the two shares are never combined internally, and no net carries x^m.
- Widths: all rotations are modulo 32. No arithmetic carries.

Test Plan:
1. Reset with start=0, then hold 10 cycles → finish=0, busy=0, x_out=m_out=0 throughout.
2. KEY_MODE=0, x=0x00000001, m=0, x0=0, m0=0, start pulsed 1 cycle → finish exactly 4 cycles after the sampling edge; x_out=0x01040405, m_out=0x00000000.
3. KEY_MODE=0, x=0x80000000, m=0xFFFFFFFF, x0=0x0000FFFF, m0=0x12345678 → x_out=0x8082FDFD, m_out=0xEDCBA987 (L(0xFFFFFFFF)=0xFFFFFFFF).
4. KEY_MODE=1, x=0x00000001, m=0x00000001, x0=m0=0 → finish 2 cycles after start; x_out=m_out=0x00802001.
5. Protocol checks:
   - start held high with inputs changed during ACC → first result uses the originally latched inputs.
   - a second operation starts on the IDLE edge after DONE.
   - finish pulses are spaced exactly NTERMS+2 cycles apart.
6. rst_n dropped at cnt=2 of an operation → outputs and finish are 0 immediately, with no finish pulse. After release, a fresh start completes normally.
   - Scoreboard check across 1000 random vectors: x_out^m_out == L(x^m)^(x0^m0).

Source files
------------

// File: rtl/sm4_masked_ltrans.sv
// sm4_masked_ltrans
//
// Masked SM4 linear transform stage, placed directly after the masked
// SubNibble (tau) stage. Each Boolean share of the S-box output goes
// through the linear transform on its own. Because L is linear, the
// masking survives without a remask. The matching share of the round
// word X0 is then XORed in to form the new masked state word.
//
// The rotation terms are accumulated serially, one term per clock. A
// KEY_MODE=0 instance takes 4 accumulate cycles and a KEY_MODE=1 instance
// takes 2. A DONE cycle then follows before the stage can accept again.
//
// Parameters:
//   KEY_MODE  0 : L(B)  = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24
//             1 : L'(B) = B ^ B<<<13 ^ B<<<23
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   level request, sampled only while idle
//   x, m    in   32-bit masked / mask shares of the tau output
//   x0, m0  in   32-bit masked / mask shares of round word X0
//   finish  out  one-cycle completion pulse
//   x_out   out  L(x) ^ x0 (held until the next completion)
//   m_out   out  L(m) ^ m0 (held until the next completion)
//   busy    out  high while accumulating or in the DONE cycle
module sm4_masked_ltrans #(
    parameter int KEY_MODE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] x,
    input  logic [31:0] m,
    input  logic [31:0] x0,
    input  logic [31:0] m0,
    output logic        finish,
    output logic [31:0] x_out,
    output logic [31:0] m_out,
    output logic        busy
);

    localparam int NTERMS = (KEY_MODE == 0) ? 4 : 2;
    localparam logic [1:0] LAST_CNT = 2'(NTERMS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] xs_q, xs_d;     // latched masked share
    logic [31:0] ms_q, ms_d;     // latched mask share
    logic [31:0] x0_q, x0_d;
    logic [31:0] m0_q, m0_d;
    logic [31:0] acc_x_q, acc_x_d;
    logic [31:0] acc_m_q, acc_m_d;
    logic [31:0] x_out_q, x_out_d;
    logic [31:0] m_out_q, m_out_d;
    logic        finish_q, finish_d;

    logic [4:0]  amt;
    logic [31:0] term_x;
    logic [31:0] term_m;

    // A rotation by 0 makes the right shift amount 32, which yields zero,
    // so the result is still correct in that case.
    function automatic logic [31:0] rotl(input logic [31:0] v, input logic [4:0] r);
        return (v << r) | (v >> (6'd32 - {1'b0, r}));
    endfunction

    function automatic logic [4:0] rot_amt(input logic [1:0] idx);
        logic [4:0] a;
        a = 5'd0;
        if (KEY_MODE == 0) begin
            case (idx)
                2'd0:    a = 5'd2;
                2'd1:    a = 5'd10;
                2'd2:    a = 5'd18;
                default: a = 5'd24;
            endcase
        end else begin
            case (idx)
                2'd0:    a = 5'd13;
                default: a = 5'd23;
            endcase
        end
        return a;
    endfunction

    // The same rotation amount is applied to both shares. The shares
    // themselves are never mixed.
    assign amt    = rot_amt(cnt_q);
    assign term_x = rotl(xs_q, amt);
    assign term_m = rotl(ms_q, amt);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        xs_d     = xs_q;
        ms_d     = ms_q;
        x0_d     = x0_q;
        m0_d     = m0_q;
        acc_x_d  = acc_x_q;
        acc_m_d  = acc_m_q;
        x_out_d  = x_out_q;
        m_out_d  = m_out_q;
        finish_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    xs_d    = x;
                    ms_d    = m;
                    x0_d    = x0;
                    m0_d    = m0;
                    // The identity term seeds the accumulator.
                    acc_x_d = x;
                    acc_m_d = m;
                    cnt_d   = 2'd0;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_x_d = acc_x_q ^ term_x;
                acc_m_d = acc_m_q ^ term_m;
                cnt_d   = cnt_q + 2'd1;
                if (cnt_q == LAST_CNT) begin
                    // The last term is folded straight into the output
                    // register together with the round-word share.
                    x_out_d  = acc_x_q ^ term_x ^ x0_q;
                    m_out_d  = acc_m_q ^ term_m ^ m0_q;
                    finish_d = 1'b1;
                    cnt_d    = 2'd0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            xs_q     <= 32'd0;
            ms_q     <= 32'd0;
            x0_q     <= 32'd0;
            m0_q     <= 32'd0;
            acc_x_q  <= 32'd0;
            acc_m_q  <= 32'd0;
            x_out_q  <= 32'd0;
            m_out_q  <= 32'd0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            xs_q     <= xs_d;
            ms_q     <= ms_d;
            x0_q     <= x0_d;
            m0_q     <= m0_d;
            acc_x_q  <= acc_x_d;
            acc_m_q  <= acc_m_d;
            x_out_q  <= x_out_d;
            m_out_q  <= m_out_d;
            finish_q <= finish_d;
        end
    end

    assign finish = finish_q;
    assign x_out  = x_out_q;
    assign m_out  = m_out_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_sm4_masked_ltrans.sv
// Bench for sm4_masked_ltrans. It drives a KEY_MODE=0 instance and a
// KEY_MODE=1 instance from shared data inputs with separate start lines.
// Each issued operation pushes its expected result onto a per-instance
// queue, and a negedge monitor pops and compares that entry on every
// finish pulse.
module tb_sm4_masked_ltrans;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [31:0] x, m, x0, m0;
    logic        fin0, fin1, busy0, busy1;
    logic [31:0] xo0, mo0, xo1, mo1;

    always #5 clk = ~clk;

    sm4_masked_ltrans #(.KEY_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .x(x), .m(m), .x0(x0), .m0(m0),
        .finish(fin0), .x_out(xo0), .m_out(mo0), .busy(busy0)
    );

    sm4_masked_ltrans #(.KEY_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .x(x), .m(m), .x0(x0), .m0(m0),
        .finish(fin1), .x_out(xo1), .m_out(mo1), .busy(busy1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] xe;
        logic [31:0] me;
        logic [31:0] ce;
        int          e0;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int   last_fin0 = -100;
    int   gap0      = 0;
    logic prev_fin0 = 1'b0;
    logic prev_fin1 = 1'b0;

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] lt0(input logic [31:0] v);
        return v ^ rl(v, 2) ^ rl(v, 10) ^ rl(v, 18) ^ rl(v, 24);
    endfunction

    function automatic logic [31:0] lt1(input logic [31:0] v);
        return v ^ rl(v, 13) ^ rl(v, 23);
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fin0) begin
            if (q0.size() == 0) begin
                chk("k0_unexpected_finish", 32'd1, 32'd0);
            end else begin
                chk("k0_x", xo0, q0[0].xe);
                chk("k0_m", mo0, q0[0].me);
                chk("k0_comb", xo0 ^ mo0, q0[0].ce);
                chk("k0_latency", 32'(cyc - q0[0].e0), 32'd4);
                void'(q0.pop_front());
            end
            chk("k0_pulse_width", {31'd0, prev_fin0}, 32'd0);
            gap0      <= cyc - last_fin0;
            last_fin0 <= cyc;
        end
        if (fin1) begin
            if (q1.size() == 0) begin
                chk("k1_unexpected_finish", 32'd1, 32'd0);
            end else begin
                chk("k1_x", xo1, q1[0].xe);
                chk("k1_m", mo1, q1[0].me);
                chk("k1_comb", xo1 ^ mo1, q1[0].ce);
                chk("k1_latency", 32'(cyc - q1[0].e0), 32'd2);
                void'(q1.pop_front());
            end
            chk("k1_pulse_width", {31'd0, prev_fin1}, 32'd0);
        end
        prev_fin0 <= fin0;
        prev_fin1 <= fin1;
    end

    task automatic push0(input logic [31:0] a, b, c, d, input int e0);
        q0.push_back(exp_t'{lt0(a) ^ c, lt0(b) ^ d, lt0(a ^ b) ^ (c ^ d), e0});
    endtask

    task automatic push1(input logic [31:0] a, b, c, d, input int e0);
        q1.push_back(exp_t'{lt1(a) ^ c, lt1(b) ^ d, lt1(a ^ b) ^ (c ^ d), e0});
    endtask

    // The next posedge after this negedge is the sampling edge, so the
    // expected e0 is cyc+1.
    task automatic issue(input logic [31:0] a, b, c, d, input bit en0, input bit en1);
        @(negedge clk);
        x = a; m = b; x0 = c; m0 = d;
        start0 = en0;
        start1 = en1;
        if (en0) push0(a, b, c, d, cyc + 1);
        if (en1) push1(a, b, c, d, cyc + 1);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (!busy0 && !busy1) return;
            @(negedge clk);
        end
        chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_fin0"}, {31'd0, fin0}, 32'd0);
        chk({tag, "_busy0"}, {31'd0, busy0}, 32'd0);
        chk({tag, "_x0"}, xo0, 32'd0);
        chk({tag, "_m0"}, mo0, 32'd0);
        chk({tag, "_fin1"}, {31'd0, fin1}, 32'd0);
        chk({tag, "_busy1"}, {31'd0, busy1}, 32'd0);
        chk({tag, "_x1"}, xo1, 32'd0);
        chk({tag, "_m1"}, mo1, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout got=%0d want=finish", cyc);
        $fatal(1);
    end

    initial begin
        int s;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        x = '0; m = '0; x0 = '0; m0 = '0;

        // Reset state, then 10 quiet cycles with start low.
        repeat (2) @(negedge clk);
        chk_zero("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_zero("idle");
        end

        // Round transform of a single bit.
        issue(32'h00000001, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        wait_idle();
        chk("t2_x", xo0, 32'h01040405);
        chk("t2_m", mo0, 32'h00000000);

        // Top bit, all-ones mask and non-zero round word.
        issue(32'h80000000, 32'hFFFFFFFF, 32'h0000FFFF, 32'h12345678, 1'b1, 1'b0);
        wait_idle();
        chk("t3_x", xo0, 32'h8082FDFD);
        chk("t3_m", mo0, 32'hEDCBA987);

        // Key-schedule transform.
        issue(32'h00000001, 32'h00000001, 32'h0, 32'h0, 1'b0, 1'b1);
        wait_idle();
        chk("t4_x", xo1, 32'h00802001);
        chk("t4_m", mo1, 32'h00802001);

        // Hold start high and change the inputs during ACC. The first
        // result must use the original inputs. The re-issue six cycles
        // later picks up the new inputs.
        @(negedge clk);
        x = 32'h12345678; m = 32'h9ABCDEF0; x0 = 32'h0F0F0F0F; m0 = 32'hF00DBEEF;
        start0 = 1'b1;
        s = cyc + 1;
        push0(x, m, x0, m0, s);
        @(negedge clk);
        x = 32'hCAFEBABE; m = 32'h13579BDF; x0 = 32'h2468ACE0; m0 = 32'h55AA33CC;
        push0(x, m, x0, m0, s + 6);
        repeat (6) @(negedge clk);
        start0 = 1'b0;
        wait_idle();
        chk("t5_gap", 32'(gap0), 32'd6);

        // Abort with reset while cnt==2. The outputs clear at once and
        // no finish appears for the aborted operation.
        @(negedge clk);
        x = 32'hDEADBEEF; m = 32'h01234567; x0 = 32'h89ABCDEF; m0 = 32'h76543210;
        start0 = 1'b1;
        push0(x, m, x0, m0, cyc + 1);
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_fin", {31'd0, fin0}, 32'd0);
        chk("t6_busy", {31'd0, busy0}, 32'd0);
        chk("t6_x", xo0, 32'd0);
        chk("t6_m", mo0, 32'd0);
        q0.delete();
        repeat (2) @(negedge clk);
        chk("t6_fin_hold", {31'd0, fin0}, 32'd0);
        rst_n = 1'b1;
        issue(32'h00000001, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        wait_idle();
        chk("t6_after_x", xo0, 32'h01040405);

        // Random vectors on both instances.
        for (int i = 0; i < 1000; i++) begin
            issue($urandom, $urandom, $urandom, $urandom, 1'b1, 1'b1);
            wait_idle();
        end

        @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
